// File: rtl/fir_ram_arbiter.sv
// fir_ram_arbiter
//   Shares one single-port tap/data lutram (one-cycle read latency) between
//   two requesters: the AXI-Lite configuration path and the FIR engine.
//   At most one access is granted per cycle. Round-robin tie-break, per-
//   requester lock for back-to-back bursts, and a saturating stall counter.
//
// Optional feature macro: ARB_FIXED_PRIO_EN
//   defined   -> ties always go to port 0 (last is tracked but unused)
//   undefined -> round-robin tie-break (requester other than last wins)
//
// Ports
//   axis_clk, axis_rst_n          clock, asynchronous active-low reset
//   rqN_valid/ready               request handshake, accepted on valid&ready
//   rqN_lock                      keep ownership after this transfer
//   rqN_we/addr/wdata             byte write enables (0 = read), address, data
//   rsN_valid/rdata               read response, one-cycle pulse, no backpressure
//   ram_EN/WE/A/Di, ram_Do        RAM port
//   stall_cnt                     saturating count of cycles with a stalled requester

module fir_ram_arbiter #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,

    input  logic                   rq0_valid,
    output logic                   rq0_ready,
    input  logic                   rq0_lock,
    input  logic [3:0]             rq0_we,
    input  logic [pADDR_WIDTH-1:0] rq0_addr,
    input  logic [pDATA_WIDTH-1:0] rq0_wdata,

    input  logic                   rq1_valid,
    output logic                   rq1_ready,
    input  logic                   rq1_lock,
    input  logic [3:0]             rq1_we,
    input  logic [pADDR_WIDTH-1:0] rq1_addr,
    input  logic [pDATA_WIDTH-1:0] rq1_wdata,

    output logic                   rs0_valid,
    output logic [pDATA_WIDTH-1:0] rs0_rdata,
    output logic                   rs1_valid,
    output logic [pDATA_WIDTH-1:0] rs1_rdata,

    output logic                   ram_EN,
    output logic [3:0]             ram_WE,
    output logic [pADDR_WIDTH-1:0] ram_A,
    output logic [pDATA_WIDTH-1:0] ram_Di,
    input  logic [pDATA_WIDTH-1:0] ram_Do,

    output logic [15:0]            stall_cnt
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_0    = 2'd1,
        OWN_1    = 2'd2
    } owner_e;

    owner_e                   owner_q, owner_d;
    logic                     last_q, last_d;
    logic                     rs0_pend_q, rs0_pend_d;
    logic                     rs1_pend_q, rs1_pend_d;
    logic [15:0]              stall_q, stall_d;
    logic [pADDR_WIDTH-1:0]   ram_a_q, ram_a_d;
    logic [pDATA_WIDTH-1:0]   ram_di_q, ram_di_d;

    logic                     win_any;
    logic                     win_sel;   // 0 = port 0, 1 = port 1
    logic                     win_lock;
    logic [3:0]               win_we;
    logic [pADDR_WIDTH-1:0]   win_addr;
    logic [pDATA_WIDTH-1:0]   win_wdata;
    logic                     stall_hit;

    // Arbitration and next-state.
    always_comb begin
        win_sel   = 1'b0;
        win_any   = 1'b0;
        win_lock  = 1'b0;
        win_we    = '0;
        win_addr  = '0;
        win_wdata = '0;
        stall_hit = 1'b0;
        owner_d   = OWN_NONE;
        last_d    = last_q;
        stall_d   = stall_q;
        ram_a_d   = ram_a_q;
        ram_di_d  = ram_di_q;

        if (owner_q == OWN_0 && rq0_valid) begin
            win_sel = 1'b0;
        end else if (owner_q == OWN_1 && rq1_valid) begin
            win_sel = 1'b1;
        end else if (rq0_valid && rq1_valid) begin
`ifdef ARB_FIXED_PRIO_EN
            win_sel = 1'b0;
`else
            win_sel = ~last_q;
`endif
        end else begin
            win_sel = rq1_valid;
        end

        // Grants are masked while reset is held so ready/EN read as their
        // reset values even if requesters keep valid asserted.
        win_any = axis_rst_n & (rq0_valid | rq1_valid);

        if (win_sel) begin
            win_lock  = rq1_lock;
            win_we    = rq1_we;
            win_addr  = rq1_addr;
            win_wdata = rq1_wdata;
        end else begin
            win_lock  = rq0_lock;
            win_we    = rq0_we;
            win_addr  = rq0_addr;
            win_wdata = rq0_wdata;
        end

        // Any valid requester always produces a grant, so "no grant" implies
        // the owner (if any) dropped valid and ownership is released.
        if (win_any) begin
            last_d   = win_sel;
            ram_a_d  = win_addr;
            ram_di_d = win_wdata;
            if (win_lock)
                owner_d = win_sel ? OWN_1 : OWN_0;
        end

        stall_hit = (rq0_valid & ~rq0_ready) | (rq1_valid & ~rq1_ready);
        if (stall_hit && stall_q != 16'hFFFF)
            stall_d = stall_q + 16'd1;
    end

    always_comb begin
        rq0_ready  = win_any & ~win_sel;
        rq1_ready  = win_any &  win_sel;
        ram_EN     = win_any;
        ram_WE     = win_any ? win_we    : 4'b0000;
        ram_A      = win_any ? win_addr  : ram_a_q;
        ram_Di     = win_any ? win_wdata : ram_di_q;
        rs0_pend_d = rq0_ready & (rq0_we == 4'b0000);
        rs1_pend_d = rq1_ready & (rq1_we == 4'b0000);
        rs0_valid  = rs0_pend_q;
        rs1_valid  = rs1_pend_q;
        rs0_rdata  = rs0_pend_q ? ram_Do : '0;
        rs1_rdata  = rs1_pend_q ? ram_Do : '0;
        stall_cnt  = stall_q;
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            owner_q    <= OWN_NONE;
            last_q     <= 1'b1;
            rs0_pend_q <= 1'b0;
            rs1_pend_q <= 1'b0;
            stall_q    <= '0;
            ram_a_q    <= '0;
            ram_di_q   <= '0;
        end else begin
            owner_q    <= owner_d;
            last_q     <= last_d;
            rs0_pend_q <= rs0_pend_d;
            rs1_pend_q <= rs1_pend_d;
            stall_q    <= stall_d;
            ram_a_q    <= ram_a_d;
            ram_di_q   <= ram_di_d;
        end
    end

endmodule

// File: tb/tb_fir_ram_arbiter.sv
module tb_fir_ram_arbiter;

`ifdef ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rq0_valid, rq0_ready, rq0_lock;
    logic [3:0]  rq0_we;
    logic [11:0] rq0_addr;
    logic [31:0] rq0_wdata;
    logic        rq1_valid, rq1_ready, rq1_lock;
    logic [3:0]  rq1_we;
    logic [11:0] rq1_addr;
    logic [31:0] rq1_wdata;
    logic        rs0_valid, rs1_valid;
    logic [31:0] rs0_rdata, rs1_rdata;
    logic        ram_EN;
    logic [3:0]  ram_WE;
    logic [11:0] ram_A;
    logic [31:0] ram_Di, ram_Do;
    logic [15:0] stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        port;
        logic [3:0]  we;
        logic [11:0] addr;
        logic [31:0] wdata;
    } grant_t;

    typedef struct {
        logic        port;
        logic [31:0] data;
    } resp_t;

    grant_t gq[$];
    resp_t  rspq[$];

    always #5 clk = ~clk;

    fir_ram_arbiter #(.pADDR_WIDTH(12), .pDATA_WIDTH(32)) dut (
        .axis_clk(clk), .axis_rst_n(rst_n),
        .rq0_valid(rq0_valid), .rq0_ready(rq0_ready), .rq0_lock(rq0_lock),
        .rq0_we(rq0_we), .rq0_addr(rq0_addr), .rq0_wdata(rq0_wdata),
        .rq1_valid(rq1_valid), .rq1_ready(rq1_ready), .rq1_lock(rq1_lock),
        .rq1_we(rq1_we), .rq1_addr(rq1_addr), .rq1_wdata(rq1_wdata),
        .rs0_valid(rs0_valid), .rs0_rdata(rs0_rdata),
        .rs1_valid(rs1_valid), .rs1_rdata(rs1_rdata),
        .ram_EN(ram_EN), .ram_WE(ram_WE), .ram_A(ram_A), .ram_Di(ram_Di),
        .ram_Do(ram_Do), .stall_cnt(stall_cnt)
    );

    // Behavioural lutram: byte-addressed, word-wide, one-cycle read latency.
    logic [31:0] mem [1024];
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        ram_Do = '0;
    end
    always @(posedge clk) begin
        if (ram_EN) begin
            if (ram_WE == 4'b0000) begin
                ram_Do <= mem[ram_A[11:2]];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (ram_WE[b]) mem[ram_A[11:2]][b*8 +: 8] <= ram_Di[b*8 +: 8];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive0(input logic v, input logic lk, input logic [3:0] we,
                          input logic [11:0] a, input logic [31:0] d);
        rq0_valid = v; rq0_lock = lk; rq0_we = we; rq0_addr = a; rq0_wdata = d;
    endtask

    task automatic drive1(input logic v, input logic lk, input logic [3:0] we,
                          input logic [11:0] a, input logic [31:0] d);
        rq1_valid = v; rq1_lock = lk; rq1_we = we; rq1_addr = a; rq1_wdata = d;
    endtask

    task automatic exp_grant(input logic p, input logic [3:0] we,
                             input logic [11:0] a, input logic [31:0] d);
        grant_t g;
        g.port = p; g.we = we; g.addr = a; g.wdata = d;
        gq.push_back(g);
    endtask

    task automatic exp_resp(input logic p, input logic [31:0] d);
        resp_t r;
        r.port = p; r.data = d;
        rspq.push_back(r);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: samples on the falling edge and consumes expected grants and
    // read responses as the DUT presents them.
    initial begin
        grant_t g;
        resp_t  r;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (rq0_ready || rq1_ready) begin
                    if (gq.size() == 0) begin
                        chk("unexpected_grant", {30'b0, rq1_ready, rq0_ready}, 32'd0);
                    end else begin
                        g = gq.pop_front();
                        chk("grant_ready", {30'b0, rq1_ready, rq0_ready}, g.port ? 32'd2 : 32'd1);
                        chk("ram_en", {31'b0, ram_EN}, 32'd1);
                        chk("ram_we", {28'b0, ram_WE}, {28'b0, g.we});
                        chk("ram_a", {20'b0, ram_A}, {20'b0, g.addr});
                        chk("ram_di", ram_Di, g.wdata);
                    end
                end
                if (rs0_valid || rs1_valid) begin
                    if (rspq.size() == 0) begin
                        chk("unexpected_resp", {30'b0, rs1_valid, rs0_valid}, 32'd0);
                    end else begin
                        r = rspq.pop_front();
                        chk("rs_valid", {30'b0, rs1_valid, rs0_valid}, r.port ? 32'd2 : 32'd1);
                        chk("rs_rdata", r.port ? rs1_rdata : rs0_rdata, r.data);
                        chk("rs_rdata_other", r.port ? rs0_rdata : rs1_rdata, 32'd0);
                    end
                end else begin
                    chk("rs_rdata_idle", rs0_rdata | rs1_rdata, 32'd0);
                end
            end
        end
    end

    initial begin
        drive0(0, 0, 4'h0, 12'h000, 32'h0);
        drive1(0, 0, 4'h0, 12'h000, 32'h0);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        // Reset state, with a requester asserting valid while reset is held.
        rq0_valid = 1'b1;
        #1;
        chk("rst_rq0_ready", {31'b0, rq0_ready}, 32'd0);
        chk("rst_ram_en", {31'b0, ram_EN}, 32'd0);
        chk("rst_ram_a", {20'b0, ram_A}, 32'd0);
        chk("rst_stall", {16'b0, stall_cnt}, 32'd0);
        chk("rst_rs", {30'b0, rs1_valid, rs0_valid}, 32'd0);
        rq0_valid = 1'b0;
        step();
        rst_n = 1'b1;

        // Lone write from port 0 is accepted the same cycle.
        drive0(1, 0, 4'hF, 12'h004, 32'hDEADBEEF);
        exp_grant(0, 4'hF, 12'h004, 32'hDEADBEEF);
        step();
        drive0(0, 0, 4'h0, 12'h000, 32'h0);
        #1;
        chk("idle_ram_en", {31'b0, ram_EN}, 32'd0);
        chk("idle_ram_we", {28'b0, ram_WE}, 32'd0);
        chk("idle_ram_a_hold", {20'b0, ram_A}, 32'h004);
        chk("idle_ram_di_hold", ram_Di, 32'hDEADBEEF);

        // Port 1 reads it back; response one cycle later on port 1 only.
        drive1(1, 0, 4'h0, 12'h004, 32'h0);
        exp_grant(1, 4'h0, 12'h004, 32'h0);
        exp_resp(1, 32'hDEADBEEF);
        step();
        drive1(0, 0, 4'h0, 12'h000, 32'h0);
        step();

        // Contention: both writing for 4 cycles, no lock.
        drive0(1, 0, 4'hF, 12'h010, 32'hA0A0A0A0);
        drive1(1, 0, 4'hF, 12'h014, 32'hB1B1B1B1);
        for (int k = 0; k < 4; k++) begin
            if (FIXED || (k % 2) == 0) exp_grant(0, 4'hF, 12'h010, 32'hA0A0A0A0);
            else                       exp_grant(1, 4'hF, 12'h014, 32'hB1B1B1B1);
            step();
        end
        drive0(0, 0, 4'h0, 12'h000, 32'h0);
        drive1(0, 0, 4'h0, 12'h000, 32'h0);
        #1;
        chk("stall_after_contention", {16'b0, stall_cnt}, 32'd4);

        // Locked burst from port 1 while port 0 waits.
        drive1(1, 1, 4'h0, 12'h004, 32'h0);
        exp_grant(1, 4'h0, 12'h004, 32'h0);
        exp_resp(1, 32'hDEADBEEF);
        step();
        drive0(1, 0, 4'h0, 12'h010, 32'h0);
        drive1(1, 1, 4'h0, 12'h014, 32'h0);
        exp_grant(1, 4'h0, 12'h014, 32'h0);
        exp_resp(1, FIXED ? 32'h0 : 32'hB1B1B1B1);
        step();
        drive1(1, 0, 4'h0, 12'h010, 32'h0);
        exp_grant(1, 4'h0, 12'h010, 32'h0);
        exp_resp(1, 32'hA0A0A0A0);
        step();
        drive1(0, 0, 4'h0, 12'h000, 32'h0);
        exp_grant(0, 4'h0, 12'h010, 32'h0);
        exp_resp(0, 32'hA0A0A0A0);
        step();
        drive0(0, 0, 4'h0, 12'h000, 32'h0);
        step();
        chk("stall_after_lock", {16'b0, stall_cnt}, 32'd6);

        // Saturation of the stall counter.
        drive0(1, 0, 4'hF, 12'h100, 32'h00000100);
        drive1(1, 0, 4'hF, 12'h104, 32'h00000104);
        for (int i = 0; i < 65540; i++) begin
            if (i == 65528) chk("stall_near_sat", {16'b0, stall_cnt}, 32'h0000FFFE);
            if (i == 65529) chk("stall_at_sat", {16'b0, stall_cnt}, 32'h0000FFFF);
            if (FIXED || (i % 2) == 1) exp_grant(0, 4'hF, 12'h100, 32'h00000100);
            else                       exp_grant(1, 4'hF, 12'h104, 32'h00000104);
            step();
        end
        drive0(0, 0, 4'h0, 12'h000, 32'h0);
        drive1(0, 0, 4'h0, 12'h000, 32'h0);
        #1;
        chk("stall_saturated", {16'b0, stall_cnt}, 32'h0000FFFF);

        // Read accepted, then reset: response dropped, outputs back to reset.
        drive0(1, 1, 4'h0, 12'h004, 32'h0);
        exp_grant(0, 4'h0, 12'h004, 32'h0);
        step();
        rst_n = 1'b0;
        drive0(0, 0, 4'h0, 12'h000, 32'h0);
        rq1_valid = 1'b1;
        #1;
        chk("rst2_rs0_valid", {31'b0, rs0_valid}, 32'd0);
        chk("rst2_rs0_rdata", rs0_rdata, 32'd0);
        chk("rst2_stall", {16'b0, stall_cnt}, 32'd0);
        chk("rst2_ram_a", {20'b0, ram_A}, 32'd0);
        chk("rst2_ram_di", ram_Di, 32'd0);
        chk("rst2_ram_en_we", {27'b0, ram_EN, ram_WE}, 32'd0);
        chk("rst2_ready", {30'b0, rq1_ready, rq0_ready}, 32'd0);
        rq1_valid = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        step();

        // After reset last=1, so port 0 wins the first tie in both modes.
        drive0(1, 0, 4'h0, 12'h004, 32'h0);
        drive1(1, 0, 4'h0, 12'h010, 32'h0);
        exp_grant(0, 4'h0, 12'h004, 32'h0);
        exp_resp(0, 32'hDEADBEEF);
        step();
        drive0(0, 0, 4'h0, 12'h000, 32'h0);
        exp_grant(1, 4'h0, 12'h010, 32'h0);
        exp_resp(1, 32'hA0A0A0A0);
        step();
        drive1(0, 0, 4'h0, 12'h000, 32'h0);
        step();
        step();

        chk("grant_queue_drained", gq.size(), 32'd0);
        chk("resp_queue_drained", rspq.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
